// File: rtl/rambam_ctrl_pkg.sv
// Shared definitions for the RAMBAM masked AES-128 sequencer.
//   ctrl_state_t : sequencer FSM states
//   sbox_tag_t   : {valid, sel, idx} tag that travels alongside each S-box byte
//   constants    : round count, S-box latency and per-round byte counts
//   make_tag()   : maps the issue byte counter onto the tag of the byte issued
package rambam_ctrl_pkg;

  localparam int ROUNDS      = 10;
  localparam int SBOX_CYCLES = 7;
  localparam int KEY_BYTES   = 4;
  localparam int STATE_BYTES = 16;
  localparam int ISSUE_BYTES = KEY_BYTES + STATE_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_DRAIN,
    ST_LINEAR,
    ST_DONE
  } ctrl_state_t;

  // sel: 0 = key-schedule byte, 1 = state byte
  typedef struct packed {
    logic       valid;
    logic       sel;
    logic [3:0] idx;
  } sbox_tag_t;

  localparam sbox_tag_t TAG_NONE = '0;

  // Key bytes occupy counter values 0..KEY_BYTES-1, state bytes follow.
  function automatic sbox_tag_t make_tag(input logic [4:0] cnt);
    sbox_tag_t t;
    t.valid = 1'b1;
    t.sel   = (cnt >= 5'(KEY_BYTES));
    t.idx   = t.sel ? 4'(cnt - 5'(KEY_BYTES)) : cnt[3:0];
    return t;
  endfunction

endpackage

// File: rtl/rambam_tag_pipe.sv
// Tag pipeline that mirrors the latency of the shared pipelined S-box.
// A tag presented on tag_in appears on tag_out exactly DEPTH cycles later.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low clear (drops every in-flight tag)
//   tag_in  : tag of the byte entering the S-box this cycle
//   tag_out : tag of the byte leaving the S-box this cycle
module rambam_tag_pipe
  import rambam_ctrl_pkg::*;
#(
  parameter int DEPTH = SBOX_CYCLES
) (
  input  logic      clk,
  input  logic      rst_n,
  input  sbox_tag_t tag_in,
  output sbox_tag_t tag_out
);

  sbox_tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= TAG_NONE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/rambam_aes_ctrl.sv
// Sequencer for the single-S-box RAMBAM masked AES-128 datapath.
// Each round issues 4 key-schedule bytes then 16 state bytes into the shared
// S-box, waits for the last write-back, then fires the linear layer.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start, round = 0
//   LOAD   | load plaintext/key, initial AddRoundKey, round := 1
//   ISSUE  | one S-box byte per cycle: key 0..3, then state 0..15
//   DRAIN  | no issue; wait for write-back of state byte 15
//   LINEAR | ShiftRows/AddRoundKey (+MixColumns except last round)
//   DONE   | one-cycle done pulse, ciphertext valid
//
// Ports:
//   clk, rst_n             : clock (rising edge), async active-low reset
//   start                  : begin encryption (sampled in IDLE only)
//   busy, done             : status; done is a one-cycle pulse
//   load_en                : load plaintext/key
//   sbox_in_valid/sel/idx  : S-box issue strobe and byte tag
//   rand_en                : advance mask randomness (tracks sbox_in_valid)
//   wb_valid/sel/idx       : S-box write-back strobe and byte tag
//   lin_en, mix_en         : linear layer enables
//   round                  : current round 1..ROUNDS, 0 in IDLE
module rambam_aes_ctrl #(
  parameter int SBOX_CYCLES = rambam_ctrl_pkg::SBOX_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       load_en,
  output logic       sbox_in_valid,
  output logic       sbox_in_sel,
  output logic [3:0] sbox_in_idx,
  output logic       rand_en,
  output logic       wb_valid,
  output logic       wb_sel,
  output logic [3:0] wb_idx,
  output logic       lin_en,
  output logic       mix_en,
  output logic [3:0] round
);

  import rambam_ctrl_pkg::*;

  localparam logic [4:0] LAST_ISSUE = 5'(ISSUE_BYTES - 1);
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);
  localparam logic [3:0] LAST_IDX   = 4'(STATE_BYTES - 1);

  ctrl_state_t state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  round_q, round_d;
  sbox_tag_t   issue_tag;
  sbox_tag_t   wb_tag;
  logic        last_wb;

  rambam_tag_pipe #(
    .DEPTH(SBOX_CYCLES)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (issue_tag),
    .tag_out(wb_tag)
  );

  // The last byte issued each round is state byte 15, so its write-back
  // marks the point where every S-box result of the round is home.
  assign last_wb = wb_tag.valid && wb_tag.sel && (wb_tag.idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    round_d   = round_q;
    issue_tag = TAG_NONE;
    busy      = 1'b0;
    done      = 1'b0;
    load_en   = 1'b0;
    lin_en    = 1'b0;
    mix_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        round_d = '0;
        if (start) begin
          round_d = 4'd1;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        busy    = 1'b1;
        load_en = 1'b1;
        cnt_d   = '0;
        state_d = ST_ISSUE;
      end

      ST_ISSUE: begin
        busy      = 1'b1;
        issue_tag = make_tag(cnt_q);
        if (cnt_q == LAST_ISSUE) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      ST_DRAIN: begin
        busy = 1'b1;
        if (last_wb) begin
          state_d = ST_LINEAR;
        end
      end

      ST_LINEAR: begin
        busy   = 1'b1;
        lin_en = 1'b1;
        mix_en = (round_q != LAST_ROUND);
        if (round_q == LAST_ROUND) begin
          state_d = ST_DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = ST_ISSUE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        round_d = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        round_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign sbox_in_valid = issue_tag.valid;
  assign sbox_in_sel   = issue_tag.sel;
  assign sbox_in_idx   = issue_tag.idx;
  assign rand_en       = issue_tag.valid;

  assign wb_valid = wb_tag.valid;
  assign wb_sel   = wb_tag.sel;
  assign wb_idx   = wb_tag.idx;

  assign round = round_q;

endmodule
